// File: rtl/cr_clic_pkg.sv
// -----------------------------------------------------------------------------
// cr_clic_pkg
// Shared definitions for the CLIC arbiter slice:
//   - arb_state_e : claim-sequencer FSM encoding (IDLE/PRESENT/CLAIM)
//   - arb_ent_t   : one tournament entry {vld, id, prio, hv}, sized for the
//                   widest legal configuration (64 slots, 8 control bits)
//   - ARB_GRP_SIZE: number of slots reduced per first-stage group
// Build macro CLIC_INTCTLBITS sets the default priority control width.
// -----------------------------------------------------------------------------
`ifndef CLIC_INTCTLBITS
`define CLIC_INTCTLBITS 3
`endif

package cr_clic_pkg;

  localparam int unsigned ARB_GRP_SIZE   = 4;
  localparam int unsigned ARB_ID_MAX_W   = 6;
  localparam int unsigned ARB_PRIO_MAX_W = 9;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_PRESENT = 2'b01,
    ARB_CLAIM   = 2'b10
  } arb_state_e;

  // Narrower configurations zero-extend into these fields, which keeps
  // unsigned priority and ID ordering intact.
  typedef struct packed {
    logic                      vld;
    logic [ARB_ID_MAX_W-1:0]   id;
    logic [ARB_PRIO_MAX_W-1:0] prio;
    logic                      hv;
  } arb_ent_t;

endpackage

// File: rtl/cr_clic_arb_node.sv
// -----------------------------------------------------------------------------
// cr_clic_arb_node
// Combinational 2-input tournament compare. The valid entry with the higher
// priority wins; on equal priority the lower ID wins.
//   a_i : first contender
//   b_i : second contender
//   y_o : winner (vld=0 when neither contender is valid)
// -----------------------------------------------------------------------------
module cr_clic_arb_node
  import cr_clic_pkg::*;
(
  input  arb_ent_t a_i,
  input  arb_ent_t b_i,
  output arb_ent_t y_o
);

  logic b_wins;

  always_comb begin
    b_wins = b_i.vld & (~a_i.vld
                        | (b_i.prio > a_i.prio)
                        | ((b_i.prio == a_i.prio) & (b_i.id < a_i.id)));
    y_o    = b_wins ? b_i : a_i;
  end

endmodule

// File: rtl/cr_clic_arb_ctrl.sv
// -----------------------------------------------------------------------------
// cr_clic_arb_ctrl
// Pipelined priority arbiter and claim sequencer between the CLIC kid array
// and the core interrupt interface.
//   clic_clk / clic_rst      : clock, synchronous active-high reset
//   kid_arb_int_req/all/hv   : per-kid request, priority, vectored flag
//   ctrl_arb_en/thresh       : global enable and priority threshold
//   arb_cpu_int_vld/id/prio/hv : presented interrupt
//   cpu_arb_int_ack          : core takes the presented interrupt
//   arb_kid_claim            : one-hot single-cycle claim to the winner
// Build macro CLIC_ARB_PREEMPT_EN lets a higher-priority candidate replace
// the presented interrupt while it waits for ack.
// -----------------------------------------------------------------------------
`ifndef CLIC_INTCTLBITS
`define CLIC_INTCTLBITS 3
`endif

module cr_clic_arb_ctrl
  import cr_clic_pkg::*;
#(
  parameter int unsigned INT_NUM = 16,
  parameter int unsigned CTLBITS = `CLIC_INTCTLBITS,
  parameter int unsigned ID_W    = 4
) (
  input  logic                         clic_clk,
  input  logic                         clic_rst,
  input  logic [INT_NUM-1:0]           kid_arb_int_req,
  input  logic [INT_NUM*(CTLBITS+1)-1:0] kid_arb_int_all,
  input  logic [INT_NUM-1:0]           kid_arb_int_hv,
  input  logic                         ctrl_arb_en,
  input  logic [CTLBITS:0]             ctrl_arb_thresh,
  output logic                         arb_cpu_int_vld,
  output logic [ID_W-1:0]              arb_cpu_int_id,
  output logic [CTLBITS:0]             arb_cpu_int_prio,
  output logic                         arb_cpu_int_hv,
  input  logic                         cpu_arb_int_ack,
  output logic [INT_NUM-1:0]           arb_kid_claim
);

  localparam int unsigned PW   = CTLBITS + 1;
  localparam int unsigned NGRP = INT_NUM / ARB_GRP_SIZE;

  // ---------------- eligibility ----------------
  arb_ent_t leaf [INT_NUM];

  always_comb begin
    for (int unsigned i = 0; i < INT_NUM; i++) begin
      leaf[i]      = '0;
      leaf[i].vld  = kid_arb_int_req[i] & ctrl_arb_en
                     & (kid_arb_int_all[i*PW +: PW] > ctrl_arb_thresh);
      leaf[i].id   = ARB_ID_MAX_W'(i % ARB_GRP_SIZE);
      leaf[i].prio = ARB_PRIO_MAX_W'(kid_arb_int_all[i*PW +: PW]);
      leaf[i].hv   = kid_arb_int_hv[i];
    end
  end

  // ---------------- stage 1: per-group winners, local IDs ----------------
  arb_ent_t s1_d [NGRP];
  arb_ent_t s1_q [NGRP];

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    arb_ent_t w01, w23;
    cr_clic_arb_node u_lo  (.a_i(leaf[4*g]),   .b_i(leaf[4*g+1]), .y_o(w01));
    cr_clic_arb_node u_hi  (.a_i(leaf[4*g+2]), .b_i(leaf[4*g+3]), .y_o(w23));
    cr_clic_arb_node u_top (.a_i(w01),         .b_i(w23),         .y_o(s1_d[g]));
  end

  always_ff @(posedge clic_clk) begin
    if (clic_rst) begin
      for (int unsigned g = 0; g < NGRP; g++) s1_q[g] <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // ---------------- stage 2: heap-ordered tree over groups ----------------
  // t2[1] is the root; leaves sit at t2[NGRP+g], so left children always
  // carry the lower IDs.
  arb_ent_t t2 [1:2*NGRP-1];
  arb_ent_t c_q;

  for (genvar g = 0; g < NGRP; g++) begin : g_s2_leaf
    always_comb begin
      t2[NGRP+g]    = s1_q[g];
      t2[NGRP+g].id = ARB_ID_MAX_W'(g * ARB_GRP_SIZE) | s1_q[g].id;
    end
  end

  for (genvar k = 1; k < NGRP; k++) begin : g_s2_node
    cr_clic_arb_node u_node (.a_i(t2[2*k]), .b_i(t2[2*k+1]), .y_o(t2[k]));
  end

  always_ff @(posedge clic_clk) begin
    if (clic_rst) c_q <= '0;
    else          c_q <= t2[1];
  end

  // ---------------- claim sequencer ----------------
  arb_state_e         state_q, state_d;
  logic               vld_q, vld_d, hv_q, hv_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [PW-1:0]      prio_q, prio_d;
  logic [INT_NUM-1:0] claim_q, claim_d;

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    id_d    = id_q;
    prio_d  = prio_q;
    hv_d    = hv_q;
    claim_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (c_q.vld) begin
          vld_d   = 1'b1;
          id_d    = ID_W'(c_q.id);
          prio_d  = PW'(c_q.prio);
          hv_d    = c_q.hv;
          state_d = ARB_PRESENT;
        end
      end
      ARB_PRESENT: begin
        if (cpu_arb_int_ack) begin
          vld_d         = 1'b0;
          claim_d[id_q] = 1'b1;
          state_d       = ARB_CLAIM;
        end else if (!kid_arb_int_req[id_q] || !ctrl_arb_en) begin
          vld_d   = 1'b0;
          state_d = ARB_IDLE;
        end
`ifdef CLIC_ARB_PREEMPT_EN
        else if (c_q.vld && (c_q.prio > ARB_PRIO_MAX_W'(prio_q))) begin
          id_d   = ID_W'(c_q.id);
          prio_d = PW'(c_q.prio);
          hv_d   = c_q.hv;
        end
`endif
      end
      ARB_CLAIM: begin
        // Two cycles here: the pulse cycle, then a quiet cycle so the kid
        // clears pending and the pipeline flushes before re-arbitration.
        if (claim_q == '0) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clic_clk) begin
    if (clic_rst) begin
      state_q <= ARB_IDLE;
      vld_q   <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
      hv_q    <= 1'b0;
      claim_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      hv_q    <= hv_d;
      claim_q <= claim_d;
    end
  end

  assign arb_cpu_int_vld  = vld_q;
  assign arb_cpu_int_id   = id_q;
  assign arb_cpu_int_prio = prio_q;
  assign arb_cpu_int_hv   = hv_q;
  assign arb_kid_claim    = claim_q;

endmodule

// File: tb/tb_cr_clic_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cr_clic_arb_ctrl
// Directed bench for cr_clic_arb_ctrl (16 slots, 4-bit priority). Inputs are
// driven 1ns after the rising edge and outputs sampled at the same point.
// Honours CLIC_ARB_PREEMPT_EN for the preemption expectations.
// -----------------------------------------------------------------------------
module tb_cr_clic_arb_ctrl;

  localparam int N  = 16;
  localparam int CB = 3;
  localparam int PW = CB + 1;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    hv  = '0;
  logic [PW-1:0]   pr [N];
  logic [N*PW-1:0] all;
  logic            en = 1'b1;
  logic [PW-1:0]   thresh = '0;
  logic            ack = 1'b0;
  logic            vld, o_hv;
  logic [IW-1:0]   id;
  logic [PW-1:0]   prio;
  logic [N-1:0]    claim;
  logic [N-1:0]    seen;

  int n_tests = 0;
  int n_fail  = 0;

  always_comb
    for (int i = 0; i < N; i++) all[i*PW +: PW] = pr[i];

  always #5 clk = ~clk;

  cr_clic_arb_ctrl #(.INT_NUM(N), .CTLBITS(CB), .ID_W(IW)) dut (
    .clic_clk        (clk),
    .clic_rst        (rst),
    .kid_arb_int_req (req),
    .kid_arb_int_all (all),
    .kid_arb_int_hv  (hv),
    .ctrl_arb_en     (en),
    .ctrl_arb_thresh (thresh),
    .arb_cpu_int_vld (vld),
    .arb_cpu_int_id  (id),
    .arb_cpu_int_prio(prio),
    .arb_cpu_int_hv  (o_hv),
    .cpu_arb_int_ack (ack),
    .arb_kid_claim   (claim)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    req = '0; hv = '0; ack = 1'b0; en = 1'b1; thresh = '0;
    for (int i = 0; i < N; i++) pr[i] = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    tick(1);
    check("rst_vld",   vld,   0);
    check("rst_id",    id,    0);
    check("rst_prio",  prio,  0);
    check("rst_hv",    o_hv,  0);
    check("rst_claim", claim, 0);
    rst = 1'b0;

    // Priority 0 is never eligible, even with threshold 0.
    req[0] = 1'b1;
    tick(5);
    check("prio0_novld", vld, 0);

    // Single request, 3-cycle latency, claim pulse.
    do_reset();
    pr[5] = 4'd3; hv[5] = 1'b1; req[5] = 1'b1;
    tick(2);
    check("single_lat2", vld, 0);
    tick(1);
    check("single_vld",  vld,  1);
    check("single_id",   id,   5);
    check("single_prio", prio, 3);
    check("single_hv",   o_hv, 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0; req[5] = 1'b0;
    check("single_claim",   claim, 32'h0020);
    check("single_vld_off", vld,   0);
    tick(1);
    check("single_claim_1cyc", claim, 0);

    // Priority and tie-break, re-arbitration 3 cycles after ack.
    do_reset();
    pr[2] = 4'd4; pr[9] = 4'd6; pr[12] = 4'd6;
    req[2] = 1'b1; req[9] = 1'b1; req[12] = 1'b1;
    tick(3);
    check("tie_vld", vld, 1);
    check("tie_id",  id,  9);
    ack = 1'b1;
    tick(1);
    ack = 1'b0; req[9] = 1'b0;
    check("tie_claim", claim, 32'h0200);
    tick(2);
    check("tie_gap_vld", vld, 0);
    tick(1);
    check("tie_next_vld",  vld,  1);
    check("tie_next_id",   id,   12);
    check("tie_next_prio", prio, 6);

    // Threshold is strictly-greater.
    do_reset();
    thresh = 4'd5; pr[1] = 4'd5; req[1] = 1'b1;
    tick(6);
    check("thr_eq_novld", vld, 0);
    pr[1] = 4'd6;
    tick(2);
    check("thr_lat2", vld, 0);
    tick(1);
    check("thr_vld", vld, 1);
    check("thr_id",  id,  1);

    // Withdraw without ack: no claim.
    do_reset();
    pr[3] = 4'd2; req[3] = 1'b1;
    tick(3);
    check("wd_vld", vld, 1);
    check("wd_id",  id,  3);
    req[3] = 1'b0;
    tick(1);
    check("wd_vld_off", vld,   0);
    check("wd_claim",   claim, 0);
    seen = '0;
    repeat (5) begin
      tick(1);
      seen = seen | claim;
    end
    check("wd_no_claim",  seen, 0);
    check("wd_settled",   vld,  0);
    // Ack and withdraw together: ack wins.
    req[3] = 1'b1;
    tick(3);
    check("wdack_vld", vld, 1);
    ack = 1'b1; req[3] = 1'b0;
    tick(1);
    ack = 1'b0;
    check("wdack_claim", claim, 32'h0008);
    check("wdack_vld_off", vld, 0);

    // Preemption (or hold when the feature is not built).
    do_reset();
    pr[0] = 4'd2; req[0] = 1'b1;
    tick(3);
    check("pre_id0", id, 0);
    pr[7] = 4'd7; req[7] = 1'b1;
    tick(3);
    check("pre_vld", vld, 1);
`ifdef CLIC_ARB_PREEMPT_EN
    check("pre_id",   id,   7);
    check("pre_prio", prio, 7);
`else
    check("pre_id",   id,   0);
    check("pre_prio", prio, 2);
`endif
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
`ifdef CLIC_ARB_PREEMPT_EN
    check("pre_claim", claim, 32'h0080);
`else
    check("pre_claim", claim, 32'h0001);
`endif

    // Reset mid-PRESENT aborts without claim.
    do_reset();
    pr[4] = 4'd3; req[4] = 1'b1;
    tick(3);
    check("mrst_vld_before", vld, 1);
    rst = 1'b1; ack = 1'b1;
    tick(1);
    rst = 1'b0; ack = 1'b0;
    check("mrst_vld",   vld,   0);
    check("mrst_id",    id,    0);
    check("mrst_prio",  prio,  0);
    check("mrst_claim", claim, 0);
    tick(1);
    check("mrst_claim2", claim, 0);
    tick(1);
    check("mrst_lat2", vld, 0);
    tick(1);
    check("mrst_resume_vld", vld, 1);
    check("mrst_resume_id",  id,  4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
